// File: rtl/decoder_pkg.sv
// Shared types for the decoder_scan block: controller state encoding.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2**N one-hot decoder with an enable; all-zero when disabled.
module decoder_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0]      in,
  input  logic              ena,
  output logic [2**N-1:0]   out
);

  localparam int M = 2**N;
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  assign out = ena ? (ONE << in) : '0;

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with valid/ready output and an optional scan mode
// that walks the index up to 2**N-1. Scan mode is built only with DECODER_SCAN_EN.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in,
  output logic              in_ready,
  output logic [2**N-1:0]   out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_done
);

  localparam int M = 2**N;

  state_e         state_q, state_d;
  logic [M-1:0]   out_q, out_d;
  logic           vld_q, vld_d;
  logic [N-1:0]   sel;
  logic [M-1:0]   oh;
  logic           accept, xfer;

`ifdef DECODER_SCAN_EN
  logic [N-1:0]   idx_q, idx_d;

  // Accepts only happen outside SCAN, so the decoder input can be muxed on state alone.
  assign sel = (state_q == SCAN) ? idx_q + 1'b1 : in;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign sel         = in;
`endif

  decoder_onehot #(.N(N)) u_onehot (
    .in  (sel),
    .ena (ena),
    .out (oh)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    vld_d     = vld_q;
    in_ready  = 1'b0;
    scan_done = 1'b0;
`ifdef DECODER_SCAN_EN
    idx_d     = idx_q;
`endif
    case (state_q)
      HOLD:    in_ready = out_ready;
      SCAN:    in_ready = 1'b0;
      default: in_ready = 1'b1;
    endcase
    accept = in_valid && in_ready;
    xfer   = vld_q && out_ready;
    if (accept) begin
      out_d   = oh;
      vld_d   = 1'b1;
      state_d = HOLD;
`ifdef DECODER_SCAN_EN
      if (mode) begin
        state_d = SCAN;
        idx_d   = in;
      end
`endif
    end else if (xfer) begin
`ifdef DECODER_SCAN_EN
      if (state_q == SCAN && idx_q != {N{1'b1}}) begin
        out_d = oh;
        idx_d = sel;
      end else begin
        scan_done = (state_q == SCAN) && !rst;
        state_d   = IDLE;
        out_d     = '0;
        vld_d     = 1'b0;
      end
`else
      state_d = IDLE;
      out_d   = '0;
      vld_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      vld_q   <= 1'b0;
`ifdef DECODER_SCAN_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
`ifdef DECODER_SCAN_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: N=1..4 instances share stimulus; a beat-level model
// predicts handshake, beats and scan_done. Scan checks apply with DECODER_SCAN_EN.
module tb_decoder_scan;

`ifdef DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, mode, in_valid, out_ready;
  logic [3:0]  in_s;
  logic [3:0][15:0] out_w;
  logic [3:0]  ir_w, ov_w, sd_w;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [(1 << (g + 1)) - 1:0] o;
    decoder_scan #(.N(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .mode      (mode),
      .in_valid  (in_valid),
      .in        (in_s[g:0]),
      .in_ready  (ir_w[g]),
      .out       (o),
      .out_valid (ov_w[g]),
      .out_ready (out_ready),
      .scan_done (sd_w[g])
    );
    assign out_w[g] = 16'(o);
  end

  int nvec = 0, nerr = 0, sd_cnt = 0, n_acc = 0;

  // Beat-level model: current beat, plus how many scan beats remain after it.
  bit          m_vld [4];
  bit          m_scan[4];
  logic [15:0] m_out [4];
  int          m_nxt [4];
  int          m_rem [4];

  task automatic chk(string tag, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic bit exp_ir(int k);
    if (!m_vld[k]) return 1'b1;
    if (m_scan[k]) return 1'b0;
    return out_ready;
  endfunction

  function automatic logic [15:0] beat(bit e, int idx);
    return e ? 16'(1 << idx) : 16'h0000;
  endfunction

  task automatic step(bit r, bit v, bit md, logic [3:0] i, bit e, bit ordy);
    rst = r; in_valid = v; mode = md; in_s = i; ena = e; out_ready = ordy;
    #1;
    if (sd_w[3]) sd_cnt++;
    if (v && exp_ir(3) && !r) n_acc++;
    for (int k = 0; k < 4; k++) begin
      int  mm, idx;
      bit  acc, xf, sd;
      mm  = 1 << (k + 1);
      idx = int'(i) % mm;
      acc = v && exp_ir(k);
      xf  = m_vld[k] && ordy;
      sd  = !r && m_scan[k] && xf && (m_rem[k] == 0);
      if (!r) begin
        chk($sformatf("in_ready[N=%0d]", k + 1), 16'(ir_w[k]), 16'(exp_ir(k)));
        chk($sformatf("scan_done[N=%0d]", k + 1), 16'(sd_w[k]), 16'(sd));
      end
      if (r) begin
        m_vld[k] = 0; m_scan[k] = 0; m_out[k] = '0; m_rem[k] = 0;
      end else if (acc) begin
        m_vld[k]  = 1;
        m_out[k]  = beat(e, idx);
        m_scan[k] = md && SCAN_EN;
        m_rem[k]  = m_scan[k] ? mm - 1 - idx : 0;
        m_nxt[k]  = idx + 1;
      end else if (xf) begin
        if (m_scan[k] && m_rem[k] > 0) begin
          m_out[k] = beat(e, m_nxt[k]);
          m_nxt[k]++;
          m_rem[k]--;
        end else begin
          m_vld[k] = 0; m_scan[k] = 0; m_out[k] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out[N=%0d]", k + 1), out_w[k], m_out[k]);
      chk($sformatf("out_valid[N=%0d]", k + 1), 16'(ov_w[k]), 16'(m_vld[k]));
    end
  endtask

  task automatic drain(int n);
    for (int c = 0; c < n; c++) step(0, 0, 0, 4'd0, 1, 1);
  endtask

  initial begin
    int sd0, cyc;
    rst = 1; ena = 0; mode = 0; in_valid = 0; out_ready = 0; in_s = '0;
    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 0; m_scan[k] = 0; m_out[k] = '0; m_nxt[k] = 0; m_rem[k] = 0;
    end
    step(1, 0, 0, 4'd0, 0, 0);
    step(1, 1, 1, 4'd9, 1, 1);
    chk("reset_out", out_w[3], 16'h0000);
    chk("reset_vld", 16'(ov_w[3]), 16'h0);

    // Direct decode with immediate consumption.
    step(0, 1, 0, 4'd5, 1, 1);
    chk("direct5_out", out_w[3], 16'h0020);
    chk("direct5_vld", 16'(ov_w[3]), 16'h1);
    step(0, 0, 0, 4'd0, 1, 1);
    chk("direct5_idle", 16'(ov_w[3]), 16'h0);

    // Back-pressure: beat held and input blocked.
    step(0, 1, 0, 4'd2, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 0, 4'd7, 1, 0);
      chk("bp_hold", out_w[3], 16'h0004);
      chk("bp_in_ready", 16'(ir_w[3]), 16'h0);
    end
    step(0, 0, 0, 4'd0, 1, 1);
    chk("bp_release", 16'(ov_w[3]), 16'h0);

    // No-bubble back-to-back direct beats, ena=0 beat in the middle.
    step(0, 1, 0, 4'd15, 1, 1);
    step(0, 1, 0, 4'd3, 0, 1);
    chk("b2b_ena0", out_w[3], 16'h0000);
    chk("b2b_vld", 16'(ov_w[3]), 16'h1);
    step(0, 1, 0, 4'd0, 1, 1);
    chk("b2b_last", out_w[3], 16'h0001);
    drain(2);

    if (SCAN_EN) begin
      step(0, 1, 1, 4'd13, 1, 1);
      chk("scan13_b1", out_w[3], 16'h2000);
      step(0, 0, 0, 4'd0, 1, 1);
      chk("scan13_b2", out_w[3], 16'h4000);
      step(0, 0, 0, 4'd0, 1, 1);
      chk("scan13_b3", out_w[3], 16'h8000);
      sd0 = sd_cnt;
      step(0, 0, 0, 4'd0, 1, 1);
      chk("scan13_done", 16'(sd_cnt - sd0), 16'd1);
      chk("scan13_idle", 16'(ov_w[3]), 16'h0);

      step(0, 1, 1, 4'd0, 1, 1);
      step(0, 0, 0, 4'd0, 0, 1);
      chk("scan_ena0", out_w[3], 16'h0000);
      step(0, 0, 0, 4'd0, 1, 0);
      chk("scan_stall", out_w[3], 16'h0000);
      step(0, 0, 0, 4'd0, 1, 1);
      chk("scan_adv", out_w[3], 16'h0004);
      drain(20);
      chk("scan_drain", 16'(ov_w[3]), 16'h0);

      step(0, 1, 1, 4'd0, 1, 1);
      for (int c = 0; c < 7; c++) step(0, 0, 0, 4'd0, 1, 1);
      chk("scan_idx7", out_w[3], 16'h0080);
      sd0 = sd_cnt;
      step(1, 0, 0, 4'd0, 1, 1);
      chk("rst_scan_out", out_w[3], 16'h0000);
      chk("rst_scan_vld", 16'(ov_w[3]), 16'h0);
      step(0, 0, 0, 4'd0, 1, 1);
      chk("rst_scan_in_ready", 16'(ir_w[3]), 16'h1);
      chk("rst_scan_no_done", 16'(sd_cnt - sd0), 16'd0);
    end else begin
      sd0 = sd_cnt;
      step(0, 1, 1, 4'd13, 1, 1);
      chk("nomode_out", out_w[3], 16'h2000);
      step(0, 0, 0, 4'd0, 1, 1);
      chk("nomode_idle", 16'(ov_w[3]), 16'h0);
      chk("nomode_no_done", 16'(sd_cnt - sd0), 16'd0);
    end
    drain(20);

    // Mixed random traffic, including scans and occasional resets.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    step(1, 0, 0, 4'd0, 0, 0);

    // Direct-mode sweep: 10000 accepts, bounded cycle budget.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      step(0, $urandom_range(0, 3) != 0, 0, 4'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("sweep_accepts", 16'(n_acc >= 10000), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
